button_pulse_repeat: RTL and testbench
======================================

// Module: button_pulse_repeat
// PURPOSE
//  Downstream consumer of the 4-button debouncer's level output (one-hot or zero).
//  Turns each debounced press into a one-clock press pulse and flags long presses.
//  Optionally emits auto-repeat pulses while a button is held.
//  Feeds the tester's command/mode FSMs, which act only on single-cycle events.
// PARAMETERS
//  FCLK           20000000  system clock frequency, Hz; c_T = FCLK/1000 clocks per ms
//  LONG_MS        500       hold time in ms before o_btns_long asserts (>=1)
//  RPT_DELAY_MS   400       hold time in ms to first auto-repeat pulse (>=1)
//  RPT_PERIOD_MS  100       ms between subsequent auto-repeat pulses (>=1)
// PORTS
//  i_clk_mhz    in   1  system clock
//  i_rstn_mhz   in   1  asynchronous, active-low reset
//  i_btns_deb   in   4  debounced button levels (debouncer output; combinational there)
//  o_btns_press out  4  one-clock pulse per press (and per repeat); one-hot
//  o_btns_long  out  4  level; the held button bit once held >= LONG_MS
//  o_btn_busy   out  1  high while any button is tracked as held
// BEHAVIOUR
//  - Reset (async, i_rstn_mhz=0): state ST_IDLE, all counters 0; all outputs 0 immediately.
//  - All outputs are registered. i_btns_deb is registered once into s_btns_q (it is
//    combinational upstream); there is no further synchronizer.
//  - Valid input: s_btns_q is 0000 or exactly one bit set. Multi-hot is treated as
//    0000 (release).
//  - Counters:
//    - 1 ms prescaler 0..c_T-1 emits s_tick on wrap.
//    - hold-ms counter saturates at LONG_MS.
//    - repeat-ms counter 0..max(RPT_DELAY_MS,RPT_PERIOD_MS).
//    - Widths use $clog2 of each maximum.
//  - Prescaler and both ms counters are cleared on entry to ST_DOWN.
//  - FSM states:
//    - ST_IDLE: on s_btns_q valid and nonzero, latch s_btn_sel <= s_btns_q, go ST_DOWN.
//      o_btns_press = s_btns_q for exactly the one cycle following that edge (cycle P).
//    - ST_DOWN: if s_btns_q != s_btn_sel, go ST_IDLE (release). Otherwise count.
//      When held ms reaches LONG_MS, o_btns_long <= s_btn_sel, i.e. asserted from cycle
//      P + LONG_MS*c_T. It stays high until release.
//      With repeat enabled, at held ms == RPT_DELAY_MS: pulse o_btns_press, clear the
//      repeat counter, go ST_RPT.
//    - ST_RPT: release goes ST_IDLE. Every RPT_PERIOD_MS ms: one-cycle pulse
//      s_btn_sel, repeat counter cleared. Repeat pulses land at cycles
//      P + (RPT_DELAY_MS + n*RPT_PERIOD_MS)*c_T, n >= 0.
//  - Latency: a nonzero input at edge k gives a press pulse visible after edge k+2.
//  - Release: o_btns_long and o_btn_busy drop on the clock after FSM returns to ST_IDLE.
//    No pulse is generated on release.
//  - Direct change from one button to another (no zero gap) = release, then a new press.
//    The new press pulse follows one cycle after returning to ST_IDLE.
//  - Press and repeat pulses never merge: at most one o_btns_press bit is high, for
//    one cycle.
//  - o_btn_busy = 1 in ST_DOWN and ST_RPT.
//  - Reset mid-hold: outputs clear at once. If the button is still held after reset
//    release, it is handled as a fresh press (new pulse).
// CONFIGURATION
//  - Macro BTN_AUTO_REPEAT_EN defined: ST_RPT and the repeat counter are built; repeat
//    pulses behave as above.
//  - Not defined: ST_RPT and the repeat counter are omitted. RPT_* are unused. One
//    press pulse per press only. Long-press is unaffected.
// TESTING  (FCLK=20000 -> c_T=20; LONG_MS=5, RPT_DELAY_MS=3, RPT_PERIOD_MS=2)
//  1 Reset: hold i_rstn_mhz=0 with i_btns_deb=0100 -> all outputs 0000/0. Release
//    reset -> press pulse 0100 two clocks later.
//  2 Tap: 0010 for 30 clocks -> exactly one 0010 pulse, o_btns_long never set,
//    o_btn_busy high ~30 clocks.
//  3 Long hold, macro off: 1000 for 200 clocks -> a single pulse at P; o_btns_long=1000
//    from P+100 until release +1-2 clocks.
//  4 Long hold, BTN_AUTO_REPEAT_EN: 0001 held 200 clocks -> pulses at P, P+60, P+100,
//    P+140, P+180 only.
//  5 Direct switch 0100->0001 mid-hold -> o_btns_long/busy drop, then a 0001 pulse;
//    no 0100 repeat afterwards.
//  6 Multi-hot 0110 from idle -> no pulse, busy stays 0. Multi-hot during hold ->
//    treated as release.

Source files
------------

// File: rtl/button_pulse_repeat.sv
// -----------------------------------------------------------------------------
// button_pulse_repeat
//
// Turns the debounced one-hot button level from the 4-button debouncer into
// single-cycle press events for the tester's command/mode FSMs, and flags long
// presses. Auto-repeat pulses while a button is held are optional.
//
// Build option:
//   BTN_AUTO_REPEAT_EN  - when defined, the repeat state and repeat counter are
//                         built and held buttons emit periodic press pulses.
//                         When undefined, RPT_* parameters have no effect.
//
// Ports:
//   i_clk_mhz     in   1  system clock
//   i_rstn_mhz    in   1  asynchronous, active-low reset
//   i_btns_deb    in   4  debounced button levels (combinational upstream)
//   o_btns_press  out  4  one-clock pulse per press / repeat, one-hot
//   o_btns_long   out  4  held button bit once held for >= LONG_MS
//   o_btn_busy    out  1  high while a button is tracked as held
// -----------------------------------------------------------------------------
module button_pulse_repeat #(
    parameter int unsigned FCLK          = 20000000,
    parameter int unsigned LONG_MS       = 500,
    parameter int unsigned RPT_DELAY_MS  = 400,
    parameter int unsigned RPT_PERIOD_MS = 100
) (
    input  logic       i_clk_mhz,
    input  logic       i_rstn_mhz,
    input  logic [3:0] i_btns_deb,
    output logic [3:0] o_btns_press,
    output logic [3:0] o_btns_long,
    output logic       o_btn_busy
);

    // Clocks per millisecond and counter widths.
    localparam int unsigned CT     = FCLK / 1000;
    localparam int unsigned PrescW = (CT > 1) ? $clog2(CT) : 1;
    localparam int unsigned HoldW  = (LONG_MS > 0) ? $clog2(LONG_MS + 1) : 1;

    // Elaboration-time sanity check of the timing parameters.
    if (CT < 2 || LONG_MS < 1 || RPT_DELAY_MS < 1 || RPT_PERIOD_MS < 1) begin : g_param_err
        $error("button_pulse_repeat: FCLK must give >=2 clocks/ms and all *_MS must be >= 1");
    end

`ifdef BTN_AUTO_REPEAT_EN
    localparam int unsigned RptMax = (RPT_DELAY_MS > RPT_PERIOD_MS) ? RPT_DELAY_MS
                                                                    : RPT_PERIOD_MS;
    localparam int unsigned RptW   = $clog2(RptMax + 1);

    typedef enum logic [1:0] {StIdle, StDown, StRpt} state_e;
`else
    typedef enum logic [1:0] {StIdle, StDown} state_e;
`endif

    state_e            state_q, state_d;
    logic [3:0]        s_btns_q;
    logic [3:0]        s_btn_sel_q, s_btn_sel_d;
    logic [PrescW-1:0] presc_q, presc_d;
    logic [HoldW-1:0]  hold_q, hold_d;
    logic [3:0]        press_q, press_d;
    logic [3:0]        long_q, long_d;
    logic              busy_q, busy_d;
`ifdef BTN_AUTO_REPEAT_EN
    logic [RptW-1:0]   rpt_q, rpt_d;
`endif

    logic       s_onehot;
    logic [3:0] s_btns_eff;
    logic       s_tick;
    logic       s_held;

    // Multi-hot is an invalid debouncer output and is treated as a release.
    assign s_onehot   = (s_btns_q != 4'b0000) && ((s_btns_q & (s_btns_q - 4'd1)) == 4'b0000);
    assign s_btns_eff = s_onehot ? s_btns_q : 4'b0000;
    assign s_tick     = (presc_q == PrescW'(CT - 1));
    // Still holding the tracked button in a non-idle state.
    assign s_held     = (state_q != StIdle) && (s_btns_eff == s_btn_sel_q);

    always_comb begin
        state_d     = state_q;
        s_btn_sel_d = s_btn_sel_q;
        presc_d     = presc_q;
        hold_d      = hold_q;
        press_d     = 4'b0000;
`ifdef BTN_AUTO_REPEAT_EN
        rpt_d       = rpt_q;
`endif

        // Shared millisecond timing while a button stays held.
        if (s_held) begin
            presc_d = s_tick ? '0 : presc_q + 1'b1;
            if (s_tick && (hold_q != HoldW'(LONG_MS))) begin
                hold_d = hold_q + 1'b1;
            end
        end

        case (state_q)
            StIdle: begin
                if (s_btns_eff != 4'b0000) begin
                    state_d     = StDown;
                    s_btn_sel_d = s_btns_eff;
                    press_d     = s_btns_eff;
                    presc_d     = '0;
                    hold_d      = '0;
`ifdef BTN_AUTO_REPEAT_EN
                    rpt_d       = '0;
`endif
                end
            end
            StDown: begin
                if (!s_held) begin
                    state_d = StIdle;
                end
`ifdef BTN_AUTO_REPEAT_EN
                else if (s_tick) begin
                    if (rpt_q == RptW'(RPT_DELAY_MS - 1)) begin
                        press_d = s_btn_sel_q;
                        rpt_d   = '0;
                        state_d = StRpt;
                    end else begin
                        rpt_d = rpt_q + 1'b1;
                    end
                end
`endif
            end
`ifdef BTN_AUTO_REPEAT_EN
            StRpt: begin
                if (!s_held) begin
                    state_d = StIdle;
                end else if (s_tick) begin
                    if (rpt_q == RptW'(RPT_PERIOD_MS - 1)) begin
                        press_d = s_btn_sel_q;
                        rpt_d   = '0;
                    end else begin
                        rpt_d = rpt_q + 1'b1;
                    end
                end
            end
`endif
            default: begin
                state_d = StIdle;
            end
        endcase

        // Outputs follow the next state so they land on the same edge as the transition.
        busy_d = (state_d != StIdle);
        long_d = (busy_d && (hold_d == HoldW'(LONG_MS))) ? s_btn_sel_d : 4'b0000;
    end

    always_ff @(posedge i_clk_mhz or negedge i_rstn_mhz) begin
        if (!i_rstn_mhz) begin
            state_q     <= StIdle;
            s_btns_q    <= 4'b0000;
            s_btn_sel_q <= 4'b0000;
            presc_q     <= '0;
            hold_q      <= '0;
            press_q     <= 4'b0000;
            long_q      <= 4'b0000;
            busy_q      <= 1'b0;
`ifdef BTN_AUTO_REPEAT_EN
            rpt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            s_btns_q    <= i_btns_deb;
            s_btn_sel_q <= s_btn_sel_d;
            presc_q     <= presc_d;
            hold_q      <= hold_d;
            press_q     <= press_d;
            long_q      <= long_d;
            busy_q      <= busy_d;
`ifdef BTN_AUTO_REPEAT_EN
            rpt_q       <= rpt_d;
`endif
        end
    end

    assign o_btns_press = press_q;
    assign o_btns_long  = long_q;
    assign o_btn_busy   = busy_q;

endmodule

// File: tb/tb_button_pulse_repeat.sv
// -----------------------------------------------------------------------------
// tb_button_pulse_repeat
//
// Directed bench for button_pulse_repeat with FCLK=20000 (20 clocks/ms),
// LONG_MS=5, RPT_DELAY_MS=3, RPT_PERIOD_MS=2. Expected press pulses (cycle and
// value) are queued by the stimulus; a monitor pops and compares them whenever
// the DUT presents a pulse. Busy/long levels are checked against hand-derived
// cycle windows. Repeat expectations follow BTN_AUTO_REPEAT_EN.
// -----------------------------------------------------------------------------
module tb_button_pulse_repeat;

    localparam int LONG_CLK = 100;  // LONG_MS * 20
    localparam int RPT_DCLK = 60;   // RPT_DELAY_MS * 20
    localparam int RPT_PCLK = 40;   // RPT_PERIOD_MS * 20
    localparam int FAR      = 1000000;

    logic       clk;
    logic       rstn;
    logic [3:0] btns;
    logic [3:0] press;
    logic [3:0] lng;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        int         c;
        logic [3:0] v;
    } exp_t;
    exp_t exq[$];

    button_pulse_repeat #(
        .FCLK          (20000),
        .LONG_MS       (5),
        .RPT_DELAY_MS  (3),
        .RPT_PERIOD_MS (2)
    ) dut (
        .i_clk_mhz    (clk),
        .i_rstn_mhz   (rstn),
        .i_btns_deb   (btns),
        .o_btns_press (press),
        .o_btns_long  (lng),
        .o_btn_busy   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got %0h want %0h", nm, cyc, act, exp);
        end
    endtask

    task automatic push(input int c, input logic [3:0] v);
        exp_t e;
        e.c = c;
        e.v = v;
        exq.push_back(e);
    endtask

    // First press pulse at p, plus repeats while held through edge last.
    task automatic push_rep(input logic [3:0] v, input int p, input int last);
        push(p, v);
`ifdef BTN_AUTO_REPEAT_EN
        for (int r = p + RPT_DCLK; r <= last; r += RPT_PCLK) push(r, v);
`endif
    endtask

    // Monitor: compares each presented pulse against the queue head.
    always @(negedge clk) begin
        if (rstn) begin
            while (exq.size() > 0 && exq[0].c < cyc) begin
                checks++;
                errors++;
                $display("FAIL missed_press cyc=%0d got none want %0h at %0d",
                         cyc, exq[0].v, exq[0].c);
                void'(exq.pop_front());
            end
            if (press != 4'b0000) begin
                if (exq.size() > 0 && exq[0].c == cyc) begin
                    chk("press_val", int'(press), int'(exq[0].v));
                    void'(exq.pop_front());
                end else begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_press cyc=%0d got %0h want 0", cyc, press);
                end
            end
        end
    end

    // Drive v for n cycles; check busy against [bs,be] and long against [ls,le]=lv.
    task automatic seg(input logic [3:0] v, input int n, input int bs, input int be,
                       input int ls, input int le, input logic [3:0] lv);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1 btns = v;
            @(negedge clk);
            chk("busy", int'(busy), int'(cyc >= bs && cyc <= be));
            chk("long", int'(lng), (cyc >= ls && cyc <= le) ? int'(lv) : 0);
        end
    endtask

    // Hold v from idle for n cycles, then release.
    task automatic hold(input logic [3:0] v, input int n);
        int t0;
        int p;
        t0 = cyc + 1;
        p  = t0 + 2;
        push_rep(v, p, t0 + n + 1);
        seg(v, n, p, t0 + n + 1, p + LONG_CLK, t0 + n + 1, v);
        seg(4'b0000, 4, p, t0 + n + 1, p + LONG_CLK, t0 + n + 1, v);
    endtask

    initial begin
        int t0;
        int p;
        int p2;
        rstn = 1'b0;
        btns = 4'b0100;

        // 1: reset holds outputs low, then held button becomes a fresh press
        repeat (3) begin
            @(negedge clk);
            chk("rst_press", int'(press), 0);
            chk("rst_long", int'(lng), 0);
            chk("rst_busy", int'(busy), 0);
        end
        @(posedge clk);
        #1 rstn = 1'b1;
        t0 = cyc;
        push(t0 + 2, 4'b0100);
        seg(4'b0100, 10, t0 + 2, t0 + 12, 1, 0, 4'b0000);
        seg(4'b0000, 4, t0 + 2, t0 + 12, 1, 0, 4'b0000);

        // 2: tap
        hold(4'b0010, 30);

        // 3/4: long hold (repeats only when the option is built)
        hold(4'b1000, 200);

        // 5: direct switch 0100 -> 0001 after long has asserted
        t0 = cyc + 1;
        p  = t0 + 2;
        p2 = t0 + 123;
        push_rep(4'b0100, p, t0 + 121);
        push(p2, 4'b0001);
        seg(4'b0100, 120, p, t0 + 121, p + LONG_CLK, t0 + 121, 4'b0100);
        seg(4'b0001, 2, p, t0 + 121, p + LONG_CLK, t0 + 121, 4'b0100);
        seg(4'b0001, 18, p2, t0 + 141, 1, 0, 4'b0000);
        seg(4'b0000, 4, p2, t0 + 141, 1, 0, 4'b0000);

        // 6a: multi-hot from idle is ignored
        seg(4'b0110, 20, 1, 0, 1, 0, 4'b0000);
        seg(4'b0000, 2, 1, 0, 1, 0, 4'b0000);

        // 6b: multi-hot during a hold acts as a release
        t0 = cyc + 1;
        p  = t0 + 2;
        push_rep(4'b0010, p, t0 + 31);
        seg(4'b0010, 30, p, t0 + 31, 1, 0, 4'b0000);
        seg(4'b0110, 10, p, t0 + 31, 1, 0, 4'b0000);
        seg(4'b0000, 3, p, t0 + 31, 1, 0, 4'b0000);

        // 7: asynchronous reset mid-hold, button still held afterwards
        t0 = cyc + 1;
        p  = t0 + 2;
        push_rep(4'b1000, p, t0 + 109);
        seg(4'b1000, 110, p, FAR, p + LONG_CLK, FAR, 4'b1000);
        #2 rstn = 1'b0;
        #1;
        chk("amid_press", int'(press), 0);
        chk("amid_long", int'(lng), 0);
        chk("amid_busy", int'(busy), 0);
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        t0 = cyc;
        push(t0 + 2, 4'b1000);
        seg(4'b1000, 10, t0 + 2, t0 + 12, 1, 0, 4'b0000);
        seg(4'b0000, 4, t0 + 2, t0 + 12, 1, 0, 4'b0000);

        repeat (5) @(negedge clk);
        chk("queue_empty", exq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
